// File: rtl/param_sequence_detector_if.sv
// Serial bit-stream bus for the sequence detector: input bit with its valid,
// the per-cycle overlap mode, the counter clear, and the match pulse and count.
// The master drives the stream; the slave (detector) returns the match outputs.
interface param_sequence_detector_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             din;
  logic             overlap;
  logic             cnt_clr;
  logic             dout;
  logic [CNT_W-1:0] match_count;

  modport master (
    output en, din, overlap, cnt_clr,
    input  dout, match_count
  );

  modport slave (
    input  en, din, overlap, cnt_clr,
    output dout, match_count
  );
endinterface

// File: rtl/param_sequence_detector.sv
// Mealy detector for a LEN-bit PATTERN (MSB received first) built on a KMP automaton.
// Latency: dout combinational in the cycle the last bit is presented; match_count one edge later.
// Backpressure: none; en=0 simply freezes the automaton, and every enabled bit is accepted.
module param_sequence_detector #(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1101,
  parameter int             CNT_W   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  param_sequence_detector_if.slave      bus
);

  localparam int SW = $clog2(LEN);
  localparam logic [SW-1:0]    LAST    = SW'(LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Received-bit order: position i of the pattern (0 = first) is PATTERN[LEN-1-i].
  // Next state after holding a prefix of length s and seeing bit b: the longest
  // pattern prefix (shorter than LEN) that is a suffix of prefix(s) followed by b.
  function automatic int kmp_next(input int s, input int b);
    int  best;
    int  idx;
    logic ok;
    logic cb;
    best = 0;
    if (s >= LEN) return 0;
    for (int k = 1; k <= s + 1 && k <= LEN - 1; k++) begin
      ok = 1'b1;
      for (int j = 0; j < k; j++) begin
        idx = s + 1 - k + j;
        cb  = (idx == s) ? b[0] : PATTERN[LEN-1-idx];
        if (cb != PATTERN[LEN-1-j]) ok = 1'b0;
      end
      if (ok) best = k;
    end
    return best;
  endfunction

  // Longest proper border of the whole pattern: where overlapping detection resumes.
  function automatic int border_len();
    int  best;
    logic ok;
    best = 0;
    for (int k = 1; k <= LEN - 1; k++) begin
      ok = 1'b1;
      for (int j = 0; j < k; j++) begin
        if (PATTERN[LEN-1-j] != PATTERN[LEN-1-(LEN-k+j)]) ok = 1'b0;
      end
      if (ok) best = k;
    end
    return best;
  endfunction

  localparam int BORDER = border_len();

  // Elaboration-time transition table; unreachable codes (s >= LEN) fall back to 0.
  logic [SW-1:0] nxt_tab [2**SW][2];

  for (genvar gs = 0; gs < 2**SW; gs++) begin : g_state
    for (genvar gb = 0; gb < 2; gb++) begin : g_bit
      localparam int NX = kmp_next(gs, gb);
      assign nxt_tab[gs][gb] = SW'(NX);
    end
  end

  logic [SW-1:0]    s;
  logic [SW-1:0]    s_nxt;
  logic             match;
  logic [CNT_W-1:0] cnt;

  assign match = bus.en && (s == LAST) && (bus.din == PATTERN[0]);

  // State register: reset discards any partial match.
  always_ff @(posedge clk) begin
    if (reset) s <= '0;
    else       s <= s_nxt;
  end

  // Next state: hold when idle, restart or jump to the border on a match, else follow KMP.
  always_comb begin
    s_nxt = s;
    if (bus.en) begin
      if (match) s_nxt = bus.overlap ? SW'(BORDER) : '0;
      else       s_nxt = nxt_tab[s][bus.din];
    end
  end

  // Mealy output: match pulse, forced low while reset is held.
  always_comb begin
    bus.dout = match & ~reset;
  end

  // Saturating match counter; a clear beats a simultaneous match.
  always_ff @(posedge clk) begin
    if (reset || bus.cnt_clr)        cnt <= '0;
    else if (match && cnt != CNT_MAX) cnt <= cnt + 1'b1;
  end

  assign bus.match_count = cnt;

endmodule

// File: tb/tb_param_sequence_detector.sv
// Drives one shared bit stream into three detector configurations and checks every
// cycle against a history-window model: a match is "last LEN accepted bits equal the
// pattern", with the history dropped on reset and on non-overlapping matches.
module tb_param_sequence_detector;

  logic clk = 1'b0;
  logic rst;
  logic en, din, ovl, clr;

  always #5 clk = ~clk;

  param_sequence_detector_if #(.CNT_W(8)) if0 ();
  param_sequence_detector_if #(.CNT_W(2)) if1 ();
  param_sequence_detector_if #(.CNT_W(8)) if2 ();

  assign if0.en = en;  assign if0.din = din;  assign if0.overlap = ovl;  assign if0.cnt_clr = clr;
  assign if1.en = en;  assign if1.din = din;  assign if1.overlap = ovl;  assign if1.cnt_clr = clr;
  assign if2.en = en;  assign if2.din = din;  assign if2.overlap = ovl;  assign if2.cnt_clr = clr;

  param_sequence_detector #(.LEN(4), .PATTERN(4'b1101), .CNT_W(8)) u_d0 (
    .clk(clk), .reset(rst), .bus(if0.slave));
  param_sequence_detector #(.LEN(4), .PATTERN(4'b1111), .CNT_W(2)) u_d1 (
    .clk(clk), .reset(rst), .bus(if1.slave));
  param_sequence_detector #(.LEN(5), .PATTERN(5'b10100), .CNT_W(8)) u_d2 (
    .clk(clk), .reset(rst), .bus(if2.slave));

  int checks   = 0;
  int failures = 0;

  int          lens [3] = '{4, 4, 5};
  logic [63:0] pats [3] = '{64'b1101, 64'b1111, 64'b10100};
  int          maxc [3] = '{255, 3, 255};

  logic [63:0] hist   [3];
  int          nvalid [3];
  int          mcnt   [3];
  int          pulses [3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic get_dout(input int i);
    case (i)
      0:       return if0.dout;
      1:       return if1.dout;
      default: return if2.dout;
    endcase
  endfunction

  function automatic logic [31:0] get_cnt(input int i);
    case (i)
      0:       return 32'(if0.match_count);
      1:       return 32'(if1.match_count);
      default: return 32'(if2.match_count);
    endcase
  endfunction

  // One clock: apply inputs, check the Mealy pulse mid-cycle, advance the model,
  // then check the registered count just after the edge.
  task automatic step(input logic e, input logic d, input logic o, input logic c, input logic r);
    logic [63:0] win;
    logic [63:0] mask;
    logic        m;
    en = e; din = d; ovl = o; clr = c; rst = r;
    #2;
    for (int i = 0; i < 3; i++) begin
      mask = (64'd1 << lens[i]) - 64'd1;
      win  = {hist[i][62:0], d};
      m    = !r && e && (nvalid[i] >= lens[i] - 1) && ((win & mask) == pats[i]);
      chk($sformatf("dout%0d", i), {31'd0, get_dout(i)}, {31'd0, m});
      if (get_dout(i)) pulses[i]++;
      if (r) begin
        hist[i] = '0; nvalid[i] = 0; mcnt[i] = 0;
      end else begin
        if (c)                        mcnt[i] = 0;
        else if (m && mcnt[i] < maxc[i]) mcnt[i]++;
        if (e) begin
          if (m && !o) begin
            hist[i] = '0; nvalid[i] = 0;
          end else begin
            hist[i] = win;
            if (nvalid[i] < 64) nvalid[i]++;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("count%0d", i), get_cnt(i), mcnt[i]);
  endtask

  task automatic start_scn();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) pulses[i] = 0;
  endtask

  // Sends n enabled bits, MSB of the low n bits first; clear optionally on the last bit.
  task automatic send(input logic [31:0] bits, input int n, input logic o, input logic clr_last);
    for (int k = 0; k < n; k++)
      step(1'b1, bits[n-1-k], o, clr_last && (k == n - 1), 1'b0);
  endtask

  initial begin
    en = 0; din = 0; ovl = 1; clr = 0; rst = 1;
    for (int i = 0; i < 3; i++) begin
      hist[i] = '0; nvalid[i] = 0; mcnt[i] = 0; pulses[i] = 0;
    end
    @(posedge clk); #1;

    // Reset state, with din high during reset
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("rst_cnt0", get_cnt(0), 0);

    // 1101 overlapping: bits 4 and 7
    start_scn();
    send(32'b1101101, 7, 1'b1, 1'b0);
    chk("ovl_pulses", pulses[0], 2);
    chk("ovl_count", get_cnt(0), 2);

    // Same stream non-overlapping: bit 4 only
    start_scn();
    send(32'b1101101, 7, 1'b0, 1'b0);
    chk("novl_pulses", pulses[0], 1);
    chk("novl_count", get_cnt(0), 1);

    // Bubbles between bits 2 and 3 with din toggling
    start_scn();
    send(32'b11, 2, 1'b1, 1'b0);
    for (int g = 0; g < 3; g++) begin
      step(1'b0, g[0], 1'b1, 1'b0, 1'b0);
      chk("gap_dout0", {31'd0, get_dout(0)}, 0);
    end
    send(32'b01101, 5, 1'b1, 1'b0);
    chk("bub_pulses", pulses[0], 2);
    chk("bub_count", get_cnt(0), 2);

    // All ones into 1111 with a 2-bit counter
    start_scn();
    send(32'h7f, 7, 1'b1, 1'b0);
    chk("ones_ovl_pulses", pulses[1], 4);
    chk("ones_ovl_sat", get_cnt(1), 3);
    start_scn();
    send(32'h7f, 7, 1'b0, 1'b0);
    chk("ones_novl_pulses", pulses[1], 1);
    chk("ones_novl_count", get_cnt(1), 1);

    // Reset mid-sequence, then a fresh match, then clear colliding with a match
    start_scn();
    send(32'b110, 3, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("rst_mid_pulses", pulses[0], 0);
    send(32'b1101, 4, 1'b1, 1'b0);
    chk("post_rst_pulses", pulses[0], 1);
    chk("post_rst_count", get_cnt(0), 1);
    start_scn();
    send(32'b1101, 4, 1'b1, 1'b1);
    chk("clr_win_pulses", pulses[0], 1);
    chk("clr_win_count", get_cnt(0), 0);

    // 10100: two matches, then KMP fallback on 1,0,1,0,1
    start_scn();
    send(32'b1010010100, 10, 1'b1, 1'b0);
    chk("p5_pulses", pulses[2], 2);
    chk("p5_count", get_cnt(2), 2);
    start_scn();
    send(32'b1010100, 7, 1'b1, 1'b0);
    chk("p5_fb_pulses", pulses[2], 1);

    // Randomized stream, overlap flipping, rare clears and resets
    start_scn();
    for (int n = 0; n < 2000; n++) begin
      step(($urandom_range(3, 0) != 0), 1'($urandom_range(1, 0)),
           1'($urandom_range(1, 0)), ($urandom_range(19, 0) == 0),
           ($urandom_range(59, 0) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_sequence_detector.md
# param_sequence_detector

Parametrised, overlap-selectable Mealy sequence detector. It generalises the fixed 4-bit "1101" overlapping detector to any pattern of 2–32 bits, adds a runtime overlap/non-overlap mode, input-valid gating and a saturating match counter. It sits on a serial bit stream: one candidate bit per enabled clock, one-cycle Mealy match pulse out.

## Interface
- `LEN`, 4: pattern length in bits; legal range 2..32.
- `PATTERN`, 4'b1101: `LEN`-bit pattern; MSB is the first bit received, LSB the last.
- `CNT_W`, 8: width of the match counter.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `en` in 1: `din` is valid this cycle; when low, the bit is ignored.
- `din` in 1: serial data bit.
- `overlap` in 1: 1 selects overlapping detection, 0 selects non-overlapping. Sampled every cycle.
- `cnt_clr` in 1: synchronous clear of `match_count`.
- `dout` out 1: Mealy match pulse (combinational from state, `din`, `en`, `reset`).
- `match_count` out `CNT_W`: registered, saturating count of matches.

## Operation
- State `s` in 0..LEN-1 is the length of the longest pattern prefix that is a suffix of the accepted history. Width is clog2(LEN).
- Transition table `next(s,b)` is the KMP automaton of `PATTERN`. It is computed at elaboration by a constant function; there is no runtime pattern memory.
- Match condition: `en` & `s == LEN-1` & `din == PATTERN[0]`.
  - `dout` = match & !`reset`.
- On a match edge:
  - `overlap`=1: `s` <= B, where B is the length of the longest proper border of `PATTERN`. For 1101, B = 1.
  - `overlap`=0: `s` <= 0.
- No match, `en`=1: `s` <= `next(s, din)`.
- `en`=0: `s` holds. `dout`=0. The counter is unaffected, except by `cnt_clr`.
- `overlap` is consulted only on match edges. Changing it mid-sequence never disturbs a partial match.
- `match_count`:
  - Increments by 1 on each match edge.
  - Saturates at 2^CNT_W-1 and never wraps.
  - `cnt_clr` forces 0. `cnt_clr` with a simultaneous match gives 0 (clear wins).
- Reset mid-sequence discards any partial match. The first bit after reset starts from `s`=0.

## Timing
- Reset values: `s`=0, `match_count`=0, `dout`=0 while `reset` is high, regardless of `din`.
- `dout` latency 0. It is high in the same cycle the last pattern bit is presented, before the capturing edge.
- `match_count` latency 1. It reflects the match after the rising edge that accepts the last bit.
- Throughput: one bit per clock.
  - Overlap mode: back-to-back matches are possible every `LEN-B` enabled cycles. For all-ones patterns (B = LEN-1), that is every cycle.
  - Non-overlap mode: at least `LEN` enabled cycles between matches.
- Gaps of `en`=0 are transparent. Only enabled bits are counted as stream positions.

## Test plan
- **Default 1101, `overlap`=1.** Period 10 ns; `reset` high 1 cycle, then `en`=1 and `din` 1,1,0,1,1,0,1.
  - `dout`=1 on bit 4 and bit 7 only.
  - `match_count` reads 1 after bit 4 and 2 after bit 7.
- **Same stream, `overlap`=0.** `dout`=1 on bit 4 only; `match_count`=1.
- **Bubbles.** Same stream as the first scenario, with `en`=0 inserted for 3 cycles between bits 2 and 3, `din` toggling during the gaps.
  - Same matches as the first scenario, now at the shifted cycles.
  - `dout`=0 in every gap cycle.
- **`LEN`=4, `PATTERN`=4'b1111, `CNT_W`=2.** `din`=1 for 7 cycles.
  - `overlap`=1: `dout` high on bits 4..7, 4 pulses; `match_count` saturates at 3.
  - `overlap`=0: 1 pulse; `match_count`=1.
- **Reset and clear collisions.**
  - Present 1,1,0, assert `reset` with `din`=1: `dout`=0 and no count.
  - After reset, 1,1,0,1: a single match.
  - Assert `cnt_clr` on the match cycle: `match_count`=0 next cycle.
- **`LEN`=5, `PATTERN`=5'b10100, `overlap`=1.** Stream 1,0,1,0,0,1,0,1,0,0.
  - Matches on bits 5 and 10.
  - No false match on 1,0,1,0,1 prefixes; checks KMP fallback from `s`=4 on `din`=1 to `s`=3.
